// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide, one step per clock.
module ex_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [31:0]     Instr_E,
    input  logic [31:0]     RD1_E,
    input  logic [31:0]     RD2_E,
    output logic            stall,
    output logic            done,
    output logic [31:0]     result
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, PREP, CALC, DONE} state_t;

    state_t              state;
    logic [2:0]          op;
    logic [XLEN-1:0]     opa;
    logic [XLEN-1:0]     opb;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic [2*XLEN-1:0]   acc;
    logic [CW-1:0]       count;
    logic                neg_res;

    logic                is_m;
    logic                accept;
    logic                is_div;
    logic                a_signed;
    logic                b_signed;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     abs_a;
    logic [XLEN-1:0]     abs_b;
    logic                div_zero;
    logic                div_ovf;
    logic                special;
    logic [XLEN-1:0]     special_res;

    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       rem_sh;
    logic [XLEN+1:0]     diff;
    logic [2*XLEN-1:0]   mul_next;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   acc_step;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     div_sel;
    logic [XLEN-1:0]     final_res;

    assign is_m   = (Instr_E[6:0] == 7'b0110011) && (Instr_E[31:25] == 7'b0000001);
    assign accept = (state == IDLE) && in_valid && is_m && !flush;
    assign stall  = accept || (state == PREP) || (state == CALC);

    // Operand signedness per funct3: MULH/MULHSU/DIV/REM sign rs1, MULH/DIV/REM sign rs2.
    assign is_div   = op[2];
    assign a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign a_neg    = a_signed && opa[XLEN-1];
    assign b_neg    = b_signed && opb[XLEN-1];
    assign abs_a    = a_neg ? -opa : opa;
    assign abs_b    = b_neg ? -opb : opb;

    assign div_zero = (opb == '0);
    assign div_ovf  = !op[0] && (opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1);
    assign special  = is_div && (div_zero || div_ovf);

    always_comb begin
        special_res = '0;
        if (op[1])
            special_res = div_zero ? opa : '0;
        else
            special_res = div_zero ? '1 : opa;
    end

    // Multiply keeps {partial high, remaining multiplier} and shifts right;
    // divide keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? mag_a : {XLEN{1'b0}})};
        mul_next = {mul_sum, acc[XLEN-1:1]};

        rem_sh   = acc[2*XLEN-1:XLEN-1];
        diff     = {1'b0, rem_sh} - {2'b00, mag_b};
        if (!diff[XLEN+1])
            div_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            div_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};

        acc_step = is_div ? div_next : mul_next;
    end

    always_comb begin
        prod      = neg_res ? -acc_step : acc_step;
        div_sel   = op[1] ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        final_res = '0;
        if (is_div)
            final_res = neg_res ? -div_sel : div_sel;
        else if (op == 3'd0)
            final_res = prod[XLEN-1:0];
        else
            final_res = prod[2*XLEN-1:XLEN];
    end

    // The final result is registered on the edge into DONE so that result and
    // done are valid together in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op      <= '0;
            opa     <= '0;
            opb     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            count   <= '0;
            neg_res <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op    <= Instr_E[14:12];
                        opa   <= RD1_E;
                        opb   <= RD2_E;
                        state <= PREP;
                    end
                end
                PREP: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (special) begin
                        result <= special_res;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        mag_a   <= abs_a;
                        mag_b   <= abs_b;
                        acc     <= is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
                        neg_res <= (is_div && op[1]) ? a_neg : (a_neg ^ b_neg);
                        count   <= CW'(ITER - 1);
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc   <= acc_step;
                        count <= count - 1'b1;
                        if (count == '0) begin
                            result <= final_res;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed literal cases plus randomized
// traffic checked every cycle against a cycle-level behavioural model.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic [31:0] Instr_E;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic        stall;
    logic        done;
    logic [31:0] result;

    ex_muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .flush    (flush),
        .Instr_E  (Instr_E),
        .RD1_E    (RD1_E),
        .RD2_E    (RD2_E),
        .stall    (stall),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] mkInstr(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    // Architectural result of an RV32M op, straight from the ISA rules.
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit isShortOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[2] && (b == 0 || (f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF);
    endfunction

    // Cycle-level model: one op in flight, finishing a fixed latency after accept.
    bit          modelOn = 1'b0;
    bit          pending = 1'b0;
    int          doneCyc = 0;
    logic [31:0] pendRes = '0;
    logic [31:0] heldRes = '0;

    always @(negedge clk) begin
        bit isM, accepted, expDone, expStall;
        if (modelOn) begin
            isM      = (Instr_E[6:0] == 7'b0110011) && (Instr_E[31:25] == 7'b0000001);
            accepted = !pending && in_valid && isM && !flush;
            expDone  = pending && (cyc == doneCyc);
            if (expDone) heldRes = pendRes;
            expStall = accepted || (pending && cyc < doneCyc);
            checkOutput("stall", {31'b0, stall}, {31'b0, expStall});
            checkOutput("done", {31'b0, done}, {31'b0, expDone});
            checkOutput("result", result, heldRes);
            if (rst) begin
                pending = 1'b0;
                heldRes = '0;
            end else if (pending) begin
                if (expDone || flush) pending = 1'b0;
            end else if (accepted) begin
                pending = 1'b1;
                pendRes = refModel(Instr_E[14:12], RD1_E, RD2_E);
                doneCyc = cyc + (isShortOp(Instr_E[14:12], RD1_E, RD2_E) ? 2 : 34);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, output int t);
        @(posedge clk); #1;
        in_valid = 1'b1;
        Instr_E  = mkInstr(f3);
        RD1_E    = a;
        RD2_E    = b;
        t        = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        RD1_E    = $urandom;
        RD2_E    = $urandom;
    endtask

    task automatic waitDone(input int limit, output int d);
        d = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                d = cyc;
                break;
            end
        end
    endtask

    task automatic runOp(input string name, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expRes, input int expLat);
        int t, d;
        applyStimulus(f3, a, b, t);
        waitDone(40, d);
        checkOutput({name, "_done_seen"}, {31'b0, (d >= 0)}, 32'd1);
        checkOutput({name, "_result"}, result, expRes);
        checkOutput({name, "_latency"}, 32'(d - t), 32'(expLat));
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t, d, t2;
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        Instr_E  = '0;
        RD1_E    = '0;
        RD2_E    = '0;
        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        modelOn = 1'b1;

        @(negedge clk);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);

        runOp("mul_7x-3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        runOp("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        runOp("mulh_m1", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 34);
        runOp("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 34);
        runOp("div_-7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        runOp("rem_-7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        runOp("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
        runOp("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 34);

        // Flush mid-divide: no done, previous result (2) retained.
        applyStimulus(3'd5, 32'd1000, 32'd3, t);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_stall", {31'b0, stall}, 32'd0);
        waitDone(40, d);
        checkOutput("flush_no_done", {31'b0, (d >= 0)}, 32'd0);
        checkOutput("flush_result", result, 32'd2);

        // Reset mid-divide: no done, result cleared.
        applyStimulus(3'd5, 32'd1000, 32'd3, t);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_stall", {31'b0, stall}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        waitDone(40, d);
        checkOutput("rst_no_done", {31'b0, (d >= 0)}, 32'd0);

        runOp("div_by_0", 3'd4, 32'd12345, 32'd0, 32'hFFFFFFFF, 2);
        runOp("rem_by_0", 3'd6, 32'd5, 32'd0, 32'd5, 2);
        runOp("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        runOp("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 2);

        // Back-to-back: second MUL presented the cycle after the first done.
        runOp("b2b_first", 3'd0, 32'd3, 32'd5, 32'd15, 34);
        @(posedge clk); #1;
        in_valid = 1'b1;
        Instr_E  = mkInstr(3'd0);
        RD1_E    = 32'd6;
        RD2_E    = 32'd7;
        t2       = cyc;
        @(negedge clk);
        checkOutput("b2b_accept_stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        waitDone(40, d);
        checkOutput("b2b_result", result, 32'd42);
        checkOutput("b2b_latency", 32'(d - t2), 32'd34);

        // ADD is not an M instruction and must be ignored.
        @(posedge clk); #1;
        in_valid = 1'b1;
        Instr_E  = {7'b0000000, 5'd2, 5'd1, 3'd0, 5'd3, 7'b0110011};
        @(negedge clk);
        checkOutput("add_stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("add_stall_after", {31'b0, stall}, 32'd0);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst      = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0: Instr_E = {7'b0000000, 5'd2, 5'd1, 3'($urandom_range(0, 7)), 5'd3, 7'b0110011};
                1: Instr_E = $urandom;
                default: Instr_E = mkInstr(3'($urandom_range(0, 7)));
            endcase
            RD1_E = randOperand();
            RD2_E = randOperand();
        end
        @(posedge clk); #1;
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
